// File: rtl/gate_function_identifier.sv
// Identifies the function of a 2-input black-box unit by probing all four (a,b)
// patterns, capturing its truth table and decoding it back to the 3-bit select.
module gate_function_identifier #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       probe_out,
    output logic       probe_a,
    output logic       probe_b,
    output logic       busy,
    output logic       done,
    output logic [2:0] sel_code,
    output logic       match,
    output logic       ambiguous,
    output logic [3:0] truth_table
);

    localparam logic [7:0] SETTLE_C = 8'(SETTLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     r_state;
    logic [1:0] r_idx;
    logic [7:0] r_cnt;
    logic [3:0] w_tt_next;

    // Returns {ambiguous, match, sel_code}; NAND maps to the lowest of its two codes.
    function automatic logic [4:0] decode_table(input logic [3:0] tt);
        logic [4:0] res;
        case (tt)
            4'b0011: res = {1'b0, 1'b1, 3'd0};
            4'b0001: res = {1'b0, 1'b1, 3'd1};
            4'b1000: res = {1'b0, 1'b1, 3'd2};
            4'b1110: res = {1'b0, 1'b1, 3'd3};
            4'b0110: res = {1'b0, 1'b1, 3'd4};
            4'b1001: res = {1'b0, 1'b1, 3'd5};
            4'b0111: res = {1'b1, 1'b1, 3'd6};
            default: res = 5'b0_0000;
        endcase
        return res;
    endfunction

    // Table as it will look once the current pattern's sample is folded in.
    always_comb begin
        w_tt_next        = truth_table;
        w_tt_next[r_idx] = probe_out;
    end

    // Probe sequencer, sampler and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= 2'd0;
            r_cnt       <= 8'd0;
            probe_a     <= 1'b0;
            probe_b     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sel_code    <= 3'd0;
            match       <= 1'b0;
            ambiguous   <= 1'b0;
            truth_table <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_state     <= RUN;
                        r_idx       <= 2'd0;
                        r_cnt       <= 8'd0;
                        truth_table <= 4'd0;
                        busy        <= 1'b1;
                        probe_a     <= 1'b0;
                        probe_b     <= 1'b0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    if (r_cnt != SETTLE_C) begin
                        r_cnt <= r_cnt + 8'd1;
                    end else begin
                        r_cnt       <= 8'd0;
                        truth_table <= w_tt_next;
                        if (r_idx != 2'd3) begin
                            r_idx              <= r_idx + 2'd1;
                            {probe_a, probe_b} <= r_idx + 2'd1;
                        end else begin
                            {ambiguous, match, sel_code} <= decode_table(w_tt_next);
                            r_idx   <= 2'd0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            probe_a <= 1'b0;
                            probe_b <= 1'b0;
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    probe_a <= 1'b0;
                    probe_b <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_function_identifier.sv
// Bench for gate_function_identifier: cycle-level model for the SETTLE=1 build,
// directed runs with literal expectations, and SETTLE=0/3 latency builds.
module tb_gate_function_identifier;

    localparam int P = 2;   // cycles per pattern in the main build (SETTLE=1)

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start = 1'b0;
    logic [2:0] sel = 3'd0;
    logic       force_en = 1'b0;
    logic       force_val = 1'b0;
    logic       chk_en = 1'b0;

    logic       pa, pb, busy, done, match, amb, po;
    logic [2:0] code;
    logic [3:0] tt;

    logic       st0 = 1'b0, pa0, pb0, busy0, done0, match0, amb0, po0;
    logic [2:0] code0;
    logic [3:0] tt0;
    logic       st3 = 1'b0, pa3, pb3, busy3, done3, match3, amb3, po3;
    logic [2:0] code3;
    logic [3:0] tt3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // The selector unit being identified, described by its boolean functions.
    function automatic logic unit_fn(input logic [2:0] s, input logic a, input logic b);
        case (s)
            3'd0:    return !a;
            3'd1:    return !(a | b);
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return !(a ^ b);
            default: return !(a & b);
        endcase
    endfunction

    assign po  = force_en ? force_val : unit_fn(sel, pa, pb);
    assign po0 = unit_fn(sel, pa0, pb0);
    assign po3 = unit_fn(sel, pa3, pb3);

    gate_function_identifier #(.SETTLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .probe_out(po),
        .probe_a(pa), .probe_b(pb), .busy(busy), .done(done),
        .sel_code(code), .match(match), .ambiguous(amb), .truth_table(tt)
    );
    gate_function_identifier #(.SETTLE(0)) u_s0 (
        .clk(clk), .rst_n(rst_n), .start(st0), .probe_out(po0),
        .probe_a(pa0), .probe_b(pb0), .busy(busy0), .done(done0),
        .sel_code(code0), .match(match0), .ambiguous(amb0), .truth_table(tt0)
    );
    gate_function_identifier #(.SETTLE(3)) u_s3 (
        .clk(clk), .rst_n(rst_n), .start(st3), .probe_out(po3),
        .probe_a(pa3), .probe_b(pb3), .busy(busy3), .done(done3),
        .sel_code(code3), .match(match3), .ambiguous(amb3), .truth_table(tt3)
    );

    // ---------------- behavioural model (main build) ----------------
    function automatic logic [3:0] unit_table(input logic [2:0] s);
        logic [3:0] t;
        for (int i = 0; i < 4; i++) t[i] = unit_fn(s, i[1], i[0]);
        return t;
    endfunction

    // {ambiguous, match, code}: search all eight selects, report the lowest hit.
    function automatic logic [4:0] model_decode(input logic [3:0] t);
        int         hits  = 0;
        logic [2:0] first = 3'd0;
        for (int s = 7; s >= 0; s--) begin
            if (unit_table(3'(s)) == t) begin
                hits++;
                first = 3'(s);
            end
        end
        return (hits == 0) ? 5'd0 : {(hits > 1), 1'b1, first};
    endfunction

    function automatic logic [3:0] with_bit(input logic [3:0] t, input logic [1:0] k, input logic v);
        logic [3:0] r;
        r    = t;
        r[k] = v;
        return r;
    endfunction

    function automatic logic exp_out(input logic [1:0] k);
        return force_en ? force_val : unit_fn(sel, k[1], k[0]);
    endfunction

    logic       m_run  = 1'b0;
    logic       m_done = 1'b0;
    int         m_t    = 0;        // edges elapsed since the accepting edge
    logic [3:0] m_tt   = 4'd0;
    logic [4:0] m_res  = 5'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run  <= 1'b0;
            m_done <= 1'b0;
            m_t    <= 0;
            m_tt   <= 4'd0;
            m_res  <= 5'd0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (!m_run) begin
            if (start) begin
                m_run <= 1'b1;
                m_t   <= 0;
                m_tt  <= 4'd0;
            end
        end else begin
            m_t <= m_t + 1;
            if ((m_t + 1) % P == 0)
                m_tt <= with_bit(m_tt, 2'((m_t + 1) / P - 1), exp_out(2'((m_t + 1) / P - 1)));
            if (m_t + 1 == 4 * P) begin
                m_run  <= 1'b0;
                m_done <= 1'b1;
                m_res  <= model_decode(with_bit(m_tt, 2'd3, exp_out(2'd3)));
            end
        end
    end

    logic [12:0] got_v, exp_v;
    assign got_v = {pa, pb, busy, done, code, match, amb, tt};
    assign exp_v = {(m_run ? 2'(m_t / P) : 2'b00), m_run, m_done,
                    m_res[2:0], m_res[3], m_res[4], m_tt};

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if (got_v !== exp_v) begin
                n_bad++;
                $display("FAIL cycle_cmp t=%0t got {pa,pb,busy,done,code,match,amb,tt}=%b expected=%b",
                         $time, got_v, exp_v);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic check(input string nm, input int got, input int expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s got=%0d expected=%0d", nm, got, expv);
        end
    endtask

    task automatic run_main(input logic [2:0] s, input logic fe, input logic fv,
                            input int rp, output int lat, output int nd);
        @(negedge clk);
        sel = s; force_en = fe; force_val = fv; start = 1'b1;
        @(posedge clk);
        lat = -1; nd = 0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            start = rp[c];
            @(posedge clk);
            #1;
            if (done) begin
                nd++;
                if (lat < 0) lat = c;
            end
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_alt(input bit three, input logic [2:0] s, output int lat);
        @(negedge clk);
        sel = s; force_en = 1'b0;
        if (three) st3 = 1'b1; else st0 = 1'b1;
        @(posedge clk);
        lat = -1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            st0 = 1'b0; st3 = 1'b0;
            @(posedge clk);
            #1;
            if ((three ? done3 : done0) && lat < 0) lat = c;
        end
    endtask

    int lat, nd;

    initial begin
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("reset_outputs", int'(got_v), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;

        // XOR unit, single start pulse
        run_main(3'd4, 1'b0, 1'b0, 0, lat, nd);
        check("xor_latency", lat, 8);
        check("xor_done_count", nd, 1);
        check("xor_table", int'(tt), 4'b0110);
        check("xor_code", int'(code), 4);
        check("xor_match", int'(match), 1);
        check("xor_ambiguous", int'(amb), 0);

        // all eight selects
        for (int s = 0; s < 8; s++) begin
            run_main(3'(s), 1'b0, 1'b0, 0, lat, nd);
            check($sformatf("sweep_code_sel%0d", s), int'(code), (s <= 5) ? s : 6);
            check($sformatf("sweep_amb_sel%0d", s), int'(amb), (s >= 6) ? 1 : 0);
            check($sformatf("sweep_match_sel%0d", s), int'(match), 1);
        end

        // stuck-at-1 unit
        run_main(3'd2, 1'b1, 1'b1, 0, lat, nd);
        check("const1_table", int'(tt), 4'b1111);
        check("const1_match", int'(match), 0);
        check("const1_code", int'(code), 0);
        check("const1_latency", lat, 8);

        // start re-pulsed at 1, 3 and 6 cycles into the run
        run_main(3'd3, 1'b0, 1'b0, (1 << 1) | (1 << 3) | (1 << 6), lat, nd);
        check("repulse_done_count", nd, 1);
        check("repulse_latency", lat, 8);
        check("repulse_code", int'(code), 3);

        // reset mid-run
        @(negedge clk);
        sel = 3'd1; force_en = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrun_reset_outputs", int'(got_v), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        nd = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        check("aborted_done_count", nd, 0);
        run_main(3'd5, 1'b0, 1'b0, 0, lat, nd);
        check("after_reset_latency", lat, 8);
        check("after_reset_code", int'(code), 5);

        // SETTLE=0 and SETTLE=3 builds
        run_alt(1'b0, 3'd2, lat);
        check("s0_latency", lat, 4);
        check("s0_table", int'(tt0), 4'b1000);
        check("s0_code", int'(code0), 2);
        check("s0_flags", int'({busy0, match0, amb0}), 3'b010);
        run_alt(1'b1, 3'd2, lat);
        check("s3_latency", lat, 16);
        check("s3_table", int'(tt3), 4'b1000);
        check("s3_code", int'(code3), 2);
        check("s3_flags", int'({busy3, match3, amb3}), 3'b010);

        // randomized stimulus against the model
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            sel       = 3'($urandom_range(0, 7));
            force_en  = ($urandom_range(0, 3) == 0);
            force_val = 1'($urandom_range(0, 1));
            start     = ($urandom_range(0, 3) == 0);
            rst_n     = ($urandom_range(0, 199) != 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (12) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
